// File: rtl/ch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ch_pkg                                                  |
// | Description : Shared types and constants for the Gilbert-Elliott     |
// |               AWGN channel model.                                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package ch_pkg;

  // Native sample width of the noise source and the modulator.
  localparam int CH_SAMPLE_W = 16;

  // Channel state; the encoding doubles as the ch_bad output bit.
  typedef enum logic {
    CH_GOOD = 1'b0,
    CH_BAD  = 1'b1
  } ch_state_t;

  // Right-shifting Fibonacci LFSR feedback mask for taps 16,14,13,11
  // (bit positions 0,2,3,5 in the shift-right orientation).
  localparam logic [15:0] C_LFSR_TAPS = 16'h002D;

  // Saturation limits at the native sample width.
  localparam logic [CH_SAMPLE_W-1:0] C_SAT_MAX = {1'b0, {(CH_SAMPLE_W-1){1'b1}}};
  localparam logic [CH_SAMPLE_W-1:0] C_SAT_MIN = {1'b1, {(CH_SAMPLE_W-1){1'b0}}};

  // One step of the maximal-length LFSR; never reaches zero from a nonzero seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & C_LFSR_TAPS), l[15:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ge_awgn_channel_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ge_awgn_channel_if                                      |
// | Description : Noise-pair input, symbol input and noisy-sample output |
// |               bundle of the Gilbert-Elliott channel.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface ge_awgn_channel_if
  import ch_pkg::*;
#(
  parameter int SAMPLE_W = CH_SAMPLE_W
);
  // Noise pairs from the Box-Muller generator
  logic                x_en;
  logic [SAMPLE_W-1:0] good_ch_AWGN;
  logic [SAMPLE_W-1:0] bad_ch_AWGN;
  // Modulated symbol stream
  logic                sym_valid;
  logic                sym_ready;
  logic [SAMPLE_W-1:0] sym_in;
  // Noisy sample stream to the demodulator
  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_data;
  logic                ch_bad;

  // Environment side: noise source, modulator and demodulator
  modport master (
    output x_en, good_ch_AWGN, bad_ch_AWGN, sym_valid, sym_in, out_ready,
    input  sym_ready, out_valid, out_data, ch_bad
  );

  // Channel model side
  modport slave (
    input  x_en, good_ch_AWGN, bad_ch_AWGN, sym_valid, sym_in, out_ready,
    output sym_ready, out_valid, out_data, ch_bad
  );
endinterface
`default_nettype wire

// File: rtl/awgn_pair_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : awgn_pair_fifo                                          |
// | Description : Synchronous FIFO for {good,bad} noise pairs with a     |
// |               synchronous flush. A push on full succeeds only when a  |
// |               pop frees a slot in the same cycle.                     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module awgn_pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic             clock,
  input  wire logic             rst_n,
  input  wire logic             flush,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] wdata,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign empty     = (r_wptr == r_rptr);
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign rdata     = r_mem[r_rptr[AW-1:0]];

  // Pointer update; flush wins over any push or pop in the same cycle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + C_PTR_ONE;
    end
  end

  // Storage array carries no reset; only slots between the pointers are read
  always_ff @(posedge clock) begin
    if (w_do_push && !flush) r_mem[r_wptr[AW-1:0]] <= wdata;
  end
endmodule
`default_nettype wire

// File: rtl/ge_awgn_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ge_awgn_channel                                         |
// | Description : Gilbert-Elliott burst-error channel. Adds GOOD or BAD  |
// |               AWGN (chosen by an LFSR-driven two-state Markov chain) |
// |               to each symbol and saturates the result.                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module ge_awgn_channel
  import ch_pkg::*;
#(
  parameter int          SAMPLE_W   = CH_SAMPLE_W,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  wire logic        clock,
  input  wire logic        rst_n,
  input  wire logic        init,
  input  wire logic [15:0] p_gb,
  input  wire logic [15:0] p_bg,
  output logic             noise_ovf,
  ge_awgn_channel_if.slave bus
);
  // Package limits are authoritative at the native width; other widths derive them
  localparam logic [SAMPLE_W-1:0] C_SAT_MAX = (SAMPLE_W == CH_SAMPLE_W) ?
      SAMPLE_W'(ch_pkg::C_SAT_MAX) : {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] C_SAT_MIN = (SAMPLE_W == CH_SAMPLE_W) ?
      SAMPLE_W'(ch_pkg::C_SAT_MIN) : {1'b1, {(SAMPLE_W-1){1'b0}}};

  ch_state_t             r_state;
  ch_state_t             w_state_next;
  logic [15:0]           r_lfsr;
  logic                  r_out_valid;
  logic [SAMPLE_W-1:0]   r_out_data;
  logic                  r_ch_bad;
  logic                  r_noise_ovf;

  logic [2*SAMPLE_W-1:0] w_fifo_rdata;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_accept;
  logic                  w_drop;
  logic [SAMPLE_W-1:0]   w_noise;
  logic [SAMPLE_W:0]     w_sum;
  logic [SAMPLE_W-1:0]   w_sat;

  // Noise pairs are stored as {good, bad}
  awgn_pair_fifo #(
    .WIDTH (2*SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .flush (init),
    .push  (bus.x_en),
    .pop   (w_accept),
    .wdata ({bus.good_ch_AWGN, bus.bad_ch_AWGN}),
    .rdata (w_fifo_rdata),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Ready is withheld during init so no symbol is handshaken and then discarded
  assign bus.sym_ready = !init && !w_fifo_empty && (!r_out_valid || bus.out_ready);
  assign w_accept      = bus.sym_valid && bus.sym_ready;
  assign w_drop        = bus.x_en && w_fifo_full && !w_accept;

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.ch_bad    = r_ch_bad;
  assign noise_ovf     = r_noise_ovf;

  // Noise selection and saturating add on SAMPLE_W+1 sign-extended operands
  always_comb begin
    w_noise = (r_state == CH_BAD) ? w_fifo_rdata[SAMPLE_W-1:0]
                                  : w_fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
    w_sum   = {bus.sym_in[SAMPLE_W-1], bus.sym_in} + {w_noise[SAMPLE_W-1], w_noise};
    case (w_sum[SAMPLE_W:SAMPLE_W-1])
      2'b01:   w_sat = C_SAT_MAX;
      2'b10:   w_sat = C_SAT_MIN;
      default: w_sat = w_sum[SAMPLE_W-1:0];
    endcase
  end

  // Markov state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)    r_state <= CH_GOOD;
    else if (init) r_state <= CH_GOOD;
    else           r_state <= w_state_next;
  end

  // Transition on accept against the pre-advance LFSR value (L is never 0)
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      case (r_state)
        CH_GOOD: if (r_lfsr <= p_gb) w_state_next = CH_BAD;
        CH_BAD:  if (r_lfsr <= p_bg) w_state_next = CH_GOOD;
        default: w_state_next = CH_GOOD;
      endcase
    end
  end

  // LFSR advances once per accepted symbol, after its value has been used
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)        r_lfsr <= LFSR_SEED;
    else if (init)     r_lfsr <= LFSR_SEED;
    else if (w_accept) r_lfsr <= lfsr_next(r_lfsr);
  end

  // Output register: load on accept, drop valid once consumed, otherwise hold
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ch_bad    <= 1'b0;
    end else if (init) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_ch_bad    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sat;
      r_ch_bad    <= (r_state == CH_BAD);
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag for a noise pair lost on a full FIFO
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)      r_noise_ovf <= 1'b0;
    else if (init)   r_noise_ovf <= 1'b0;
    else if (w_drop) r_noise_ovf <= 1'b1;
  end
endmodule
`default_nettype wire

// File: doc/ge_awgn_channel.md
Name: ge_awgn_channel

Overview:
Gilbert-Elliott burst-error channel model that sits directly downstream of boxmuller. It buffers the {good_ch_AWGN, bad_ch_AWGN} noise pairs that boxmuller emits on x_en. It adds the noise sample for the current channel state to each modulated symbol and produces a saturated noisy sample for the demodulator. A two-state Markov chain, driven by an internal LFSR, selects GOOD or BAD noise for each symbol.

Parameters:
SAMPLE_W, 16, width of symbol, noise and output samples (signed two's complement, same Q-format for all three).
FIFO_DEPTH, 4, depth of the noise-pair buffer (power of 2, >= 2).
LFSR_SEED, 16'hACE1, reset/init value of the state-transition LFSR (must be nonzero).

Ports:
clock  in  1  system clock; all logic is rising-edge.
rst_n  in  1  asynchronous active-low reset.
init  in  1  synchronous clear: flushes the FIFO, sets state to GOOD, reloads LFSR_SEED, clears noise_ovf.
x_en  in  1  noise pair valid (from boxmuller).
good_ch_AWGN  in  SAMPLE_W  GOOD-state noise sample.
bad_ch_AWGN  in  SAMPLE_W  BAD-state noise sample.
p_gb  in  16  GOOD->BAD transition threshold.
p_bg  in  16  BAD->GOOD transition threshold.
sym_valid  in  1  input symbol valid.
sym_ready  out  1  input symbol accepted this cycle.
sym_in  in  SAMPLE_W  input symbol.
out_valid  out  1  noisy sample valid.
out_ready  in  1  downstream ready.
out_data  out  SAMPLE_W  symbol + selected noise, saturated.
ch_bad  out  1  state used for the sample currently on out_data (1 = BAD).
noise_ovf  out  1  sticky flag: a noise pair was dropped.

Behaviour:
- Reset (rst_n=0, async) and init=1 (sync) have identical effect: FIFO empty, state GOOD, LFSR=LFSR_SEED, out_valid=0, out_data=0, ch_bad=0, noise_ovf=0. init has priority over all other activity in its cycle.
- FIFO write: on x_en=1 the pair {good,bad} is pushed. If the FIFO is full and no pop occurs in the same cycle, the pair is dropped and noise_ovf is set. If full and a pop occurs in the same cycle, the write succeeds.
- sym_ready = FIFO not empty AND (out_valid=0 OR out_ready=1). Combinational, with no dependence on sym_valid.
- Accept = sym_valid AND sym_ready. On accept:
  - pop one pair;
  - out_data <= sat(sym_in + (state==BAD ? bad : good));
  - ch_bad <= state;
  - out_valid <= 1.
  Latency is 1 cycle from accept to out_valid.
- If out_valid=1 AND out_ready=1 AND there is no accept, out_valid <= 0. out_data holds its value while out_valid=1 AND out_ready=0.
- Addition: sign-extend both operands to SAMPLE_W+1 bits. Clamp the result to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1], i.e. 0x8000..0x7FFF at the default width.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, maximal length, never 0. It advances only on accept, after its current value has been used.
- State machine, on accept, using the pre-advance LFSR value L:
  - GOOD: go to BAD if L <= p_gb, else stay GOOD.
  - BAD: go to GOOD if L <= p_bg, else stay BAD.
  - p=0 means never transition (L is never 0). p=0xFFFF means always transition.
  - The new state applies to the next symbol, not the current one.
- p_gb and p_bg are sampled at each accept and may change at any time.
- A FIFO-empty stall never drops a symbol: the symbol is held upstream because sym_ready=0.

Decomposition:
- Shared package ch_pkg holds:
  - SAMPLE_W default;
  - the ch_state_t enum {CH_GOOD=0, CH_BAD=1};
  - LFSR tap constant;
  - saturation limit constants.
- Sub-module awgn_pair_fifo: synchronous FIFO of 2*SAMPLE_W-bit entries with push, pop, full, empty and a flush input driven by init.
- The top level contains the Markov FSM, LFSR, adder/saturator and output register.

Test Plan:
- Basic add: p_gb=0; push pair {0x0100, 0x0F00}; send sym_in=0x1000 -> one cycle later out_valid=1, out_data=0x1100, ch_bad=0.
- Saturation: p_gb=0. Good noise 0x0200 with sym 0x7F00 -> 0x7FFF. Good noise 0xFE00 with sym 0x8100 -> 0x8000.
- Forced toggling: p_gb=p_bg=0xFFFF; push 4 pairs, good=0x0001 and bad=0x0010 each; send sym=0 x4 -> out_data 0x0001, 0x0010, 0x0001, 0x0010 and ch_bad 0,1,0,1.
- Overflow: 5 consecutive x_en pulses with no symbols -> noise_ovf=1; exactly 4 symbols accepted, 5th symbol sees sym_ready=0. Push on full with a simultaneous pop -> no overflow.
- Backpressure: out_ready=0 with out_valid=1 -> sym_ready=0, out_data stable for 10 cycles. Raise out_ready -> the next symbol is accepted in the same cycle.
- Reset/init mid-stream: assert init with 3 pairs queued, state BAD and out_valid=1 -> next cycle FIFO empty, out_valid=0, ch_bad=0, noise_ovf=0, sym_ready=0. Async rst_n pulse between clock edges -> outputs clear immediately.
